// File: rtl/mem_b_pkg.sv
// Shared defaults and helpers for the B-operand skew buffer.
// Column depths are derived here so the top and any future users agree on the skew.
package mem_b_pkg;

    localparam int DEFAULT_BITS_AB = 8;
    localparam int DEFAULT_DIM     = 8;

    // Column c must trail column 0 by c cycles on top of the DIM-deep base delay.
    function automatic int col_depth(input int dim, input int col);
        return dim + col;
    endfunction

endpackage

// File: rtl/mem_b_delay_line.sv
// Enable-gated delay line of DEPTH stages followed by an output register.
// A sample entering on enabled edge k leaves on dout after enabled edge k+DEPTH.
module mem_b_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout
);

    logic signed [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset, not just dout, so a mid-stream reset flushes in-flight data.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
            dout <= '0;
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
            dout <= stage[DEPTH-1];
        end
    end

endmodule

// File: rtl/mem_b.sv
// Input skew buffer for the B operand of a DIM x DIM systolic array.
// Each column gets its own delay line, one cycle longer per column, forming the diagonal wavefront.
module mem_b
    import mem_b_pkg::*;
#(
    parameter int BITS_AB = DEFAULT_BITS_AB,
    parameter int DIM     = DEFAULT_DIM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic signed [BITS_AB-1:0] Bin  [DIM-1:0],
    output logic signed [BITS_AB-1:0] Bout [DIM-1:0]
);

    for (genvar c = 0; c < DIM; c++) begin : g_col
        mem_b_delay_line #(
            .WIDTH (BITS_AB),
            .DEPTH (col_depth(DIM, c))
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .din   (Bin[c]),
            .dout  (Bout[c])
        );
    end

endmodule

// File: tb/tb_mem_b.sv
// Directed testbench for mem_b with DIM=8, BITS_AB=8.
// Each scenario task drives its stimulus and compares Bout against hand-derived values.
module tb_mem_b;

    localparam int DIM  = 8;
    localparam int BITS = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic signed [BITS-1:0] bin  [DIM-1:0];
    logic signed [BITS-1:0] bout [DIM-1:0];

    int n_vec = 0;
    int n_err = 0;

    mem_b #(.BITS_AB(BITS), .DIM(DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .Bin   (bin),
        .Bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic set_row(input logic signed [BITS-1:0] v);
        for (int c = 0; c < DIM; c++) bin[c] = v;
    endtask

    // One clock edge with the given enable; returns 1 time unit after the edge.
    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_row('0);
        en    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_row(8'sh7F);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            for (int c = 0; c < DIM; c++) begin
                n_vec++;
                if (bout[c] !== 8'sh00) begin
                    n_err++;
                    $display("FAIL reset_hold col%0d: got %0d want 0", c, bout[c]);
                end
            end
        end
        rst_n = 1'b0;
        for (int k = 1; k <= DIM; k++) begin
            step(1'b1);
            for (int c = 0; c < DIM; c++) begin
                n_vec++;
                if (bout[c] !== 8'sh00) begin
                    n_err++;
                    $display("FAIL reset_release edge%0d col%0d: got %0d want 0", k, c, bout[c]);
                end
            end
        end
        step(1'b1);
        n_vec++;
        if (bout[0] !== 8'sh7F) begin
            n_err++;
            $display("FAIL reset_first_data col0: got %0d want 127", bout[0]);
        end
        n_vec++;
        if (bout[1] !== 8'sh00) begin
            n_err++;
            $display("FAIL reset_first_data col1: got %0d want 0", bout[1]);
        end
    endtask

    task automatic test_single_matrix();
        int r;
        logic signed [BITS-1:0] want;
        do_reset();
        for (int e = 1; e <= 23; e++) begin
            for (int c = 0; c < DIM; c++) bin[c] = (e <= DIM) ? 8'(10 * (e - 1) + c) : 8'sh00;
            step(1'b1);
            if (e <= DIM) begin
                n_vec++;
                if (bout[e-1] !== 8'sh00) begin
                    n_err++;
                    $display("FAIL fill_zero edge%0d col%0d: got %0d want 0", e, e - 1, bout[e-1]);
                end
            end else begin
                r = e - DIM - 1;
                for (int c = 0; c < DIM; c++) begin
                    want = (r - c >= 0 && r - c < DIM) ? 8'(10 * (r - c) + c) : 8'sh00;
                    n_vec++;
                    if (bout[c] !== want) begin
                        n_err++;
                        $display("FAIL skew edge%0d col%0d: got %0d want %0d", e, c, bout[c], want);
                    end
                end
            end
            if (e == 10) begin
                n_vec++;
                if (bout[0] !== 8'sd10 || bout[1] !== 8'sd1 || bout[2] !== 8'sd0) begin
                    n_err++;
                    $display("FAIL skew_edge10: got %0d,%0d,%0d want 10,1,0", bout[0], bout[1], bout[2]);
                end
            end
            if (e == 23) begin
                n_vec++;
                if (bout[7] !== 8'sd77 || bout[6] !== 8'sd0) begin
                    n_err++;
                    $display("FAIL skew_edge23: got col7=%0d col6=%0d want 77,0", bout[7], bout[6]);
                end
            end
        end
    endtask

    task automatic test_signed();
        logic signed [BITS-1:0] vals [3];
        logic signed [BITS-1:0] want;
        vals[0] = -8'sd128;
        vals[1] = -8'sd1;
        vals[2] = 8'sd127;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            set_row('0);
            if (e <= 3) bin[3] = vals[e-1];
            step(1'b1);
            if (e >= 11) begin
                want = (e == 11) ? 8'sh00 : vals[e-12];
                n_vec++;
                if (bout[3] !== want) begin
                    n_err++;
                    $display("FAIL signed edge%0d col3: got %h want %h", e, bout[3], want);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            set_row((e == 1) ? 8'sd5 : 8'sd0);
            step(1'b1);
        end
        set_row(8'sh55);
        for (int k = 0; k < 4; k++) begin
            step(1'b0);
            for (int c = 0; c < DIM; c++) begin
                n_vec++;
                if (bout[c] !== 8'sh00) begin
                    n_err++;
                    $display("FAIL stall_zero cyc%0d col%0d: got %0d want 0", k, c, bout[c]);
                end
            end
        end
        set_row('0);
        for (int e = 6; e <= 9; e++) begin
            step(1'b1);
            n_vec++;
            if (bout[0] !== ((e == 9) ? 8'sd5 : 8'sd0)) begin
                n_err++;
                $display("FAIL stall_latency en_edge%0d col0: got %0d want %0d", e, bout[0], (e == 9) ? 5 : 0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0);
            n_vec++;
            if (bout[0] !== 8'sd5 || bout[1] !== 8'sd0) begin
                n_err++;
                $display("FAIL stall_frozen cyc%0d: got col0=%0d col1=%0d want 5,0", k, bout[0], bout[1]);
            end
        end
        step(1'b1);
        n_vec++;
        if (bout[0] !== 8'sd0 || bout[1] !== 8'sd5) begin
            n_err++;
            $display("FAIL stall_resume: got col0=%0d col1=%0d want 0,5", bout[0], bout[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [BITS-1:0] mat [10][DIM][DIM];
        logic signed [BITS-1:0] want;
        int r;
        for (int m = 0; m < 10; m++)
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    mat[m][i][j] = 8'($urandom_range(255));
        do_reset();
        for (int m = 0; m < 10; m++) begin
            for (int e = 1; e <= 24; e++) begin
                for (int c = 0; c < DIM; c++) bin[c] = (e <= DIM) ? mat[m][e-1][c] : 8'sh00;
                step(1'b1);
                if (e >= DIM + 1 && e <= DIM + 15) begin
                    r = e - DIM - 1;
                    for (int c = 0; c < DIM; c++) begin
                        want = (r - c >= 0 && r - c < DIM) ? mat[m][r-c][c] : 8'sh00;
                        n_vec++;
                        if (bout[c] !== want) begin
                            n_err++;
                            $display("FAIL b2b mat%0d r%0d col%0d: got %0d want %0d", m, r, c, bout[c], want);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            for (int c = 0; c < DIM; c++) bin[c] = (e <= DIM) ? 8'(10 * (e - 1) + c) : 8'sh00;
            step(1'b1);
        end
        n_vec++;
        if (bout[0] !== 8'sd30 || bout[2] !== 8'sd12) begin
            n_err++;
            $display("FAIL async_pre: got col0=%0d col2=%0d want 30,12", bout[0], bout[2]);
        end
        #2;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < DIM; c++) begin
            n_vec++;
            if (bout[c] !== 8'sh00) begin
                n_err++;
                $display("FAIL async_clear col%0d: got %0d want 0", c, bout[c]);
            end
        end
        #1;
        rst_n = 1'b0;
        set_row('0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            for (int c = 0; c < DIM; c++) begin
                n_vec++;
                if (bout[c] !== 8'sh00) begin
                    n_err++;
                    $display("FAIL async_after cyc%0d col%0d: got %0d want 0", k, c, bout[c]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        set_row('0);
        #1;
        test_reset();
        test_single_matrix();
        test_signed();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_b.md
Name: mem_b

Overview:
- Input skew buffer for the B operand of a DIM x DIM systolic array.
- Accepts one row of B per enabled cycle (DIM signed elements).
- Drives each column out through its own delay line, so column c reaches the array c cycles after column 0.
- This produces the diagonal (staggered) wavefront the array needs.
- Pure data movement: no arithmetic.

Parameters:
- BITS_AB, 8, width of each signed element.
- DIM, 8, array dimension: number of columns and base delay-line depth.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-high reset; clears all storage while asserted.
- en  input  1  shift enable; when 1 every delay line advances one stage per clock.
- Bin  input  DIM x BITS_AB (signed, unpacked [DIM-1:0])  row of B; Bin[c] is the column c element.
- Bout  output  DIM x BITS_AB (signed, unpacked [DIM-1:0])  skewed outputs; Bout[c] feeds array column c.

Behaviour:
- Column c is a shift register of exactly DIM+c stages of BITS_AB bits. Column 0 has DIM stages; column DIM-1 has 2*DIM-1 stages.
- Bout[c] is the oldest (last) stage of column c, registered; no combinational path from Bin to Bout.
- On a rising edge with en=1, all columns shift: stage 0 loads Bin[c] and every other stage loads its predecessor.
- On a rising edge with en=0, every stage holds; Bout is stable.
- Latency: Bin[c] sampled at enabled edge k appears on Bout[c] immediately after enabled edge k+DIM+c (counting enabled edges only).
- Loading rows B[0..DIM-1] on DIM consecutive enabled edges, then zeros, gives the following after the (DIM+1+r)-th enabled edge, r = 0..2*DIM-2:
  - Bout[c] = B[r-c][c] when 0 <= r-c < DIM;
  - Bout[c] = 0 otherwise.
- Reset: while rst_n=1, all stages of all columns are 0 asynchronously, so Bout = all zeros. Reset dominates en.
- Reset mid-operation discards all in-flight data. After release, only zeros emerge until new data has traversed its line.
- No full/empty flags.
- Streaming is continuous: the next matrix may follow immediately. Zeros shifted in between matrices are delivered as zeros.
- Values pass through bit-exact; sign is preserved; no saturation or extension.

Decomposition:
- No shared package is required. Element width is carried by parameter BITS_AB.
- One natural sub-module: mem_b_delay_line, parameters WIDTH and DEPTH, ports clk, rst_n, en, din, dout.
- mem_b instantiates DIM copies in a generate loop, with DEPTH = DIM+c for column c.

Test Plan (DIM=8, BITS_AB=8):
- Reset: hold rst_n=1 with Bin all 0x7F and en=1 -> Bout all 0. After release, Bout stays 0 for 8 enabled edges.
- Single-matrix skew:
  - Stimulus: B[r][c] = 10*r+c on 8 enabled edges, then zeros.
  - After edge 9: Bout = {0, 0, 0, 0, 0, 0, 0, 0} with Bout[0]=0 (= B[0][0]).
  - After edge 10: Bout[0]=10, Bout[1]=1, the rest 0.
  - After edge 23: Bout[7]=77, the rest 0.
- Fill-phase zeros: during loading, after enabled edge k (1..8), Bout[k-1]=0.
- Signed values: load column 3 with -128, -1, 127 in rows 0..2 -> Bout[3] shows 0x80, 0xFF, 0x7F after edges 12, 13, 14.
- Enable stall:
  - Stimulus: load row 0 = all 5; deassert en for 4 cycles mid-stream.
  - Response: Bout is frozen during the stall; Bout[0]=5 appears after the 9th enabled edge, not the 9th clock.
- Back-to-back matrices: 10 random matrices, each 8 load edges + 1 zero edge + 15 drain edges, en held high throughout -> every drained 15x8 window matches B[r-c][c] or 0 with zero mismatches.
- Async reset mid-drain: assert rst_n between clock edges after edge 12 -> Bout goes to 0 immediately, without waiting for a clock edge.
